keypad_matrix_emu: RTL



---
 rtl/keypad_pkg.sv | 15 +
 rtl/keypad_matrix_emu_if.sv | 22 ++
 rtl/keypad_emu_timer.sv | 33 +++
 rtl/keypad_matrix_emu.sv | 93 +++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared definitions for the keypad matrix emulator: arrow-key codes and FSM state encoding.
package keypad_pkg;

  localparam logic [3:0] KEY_LEFT  = 4'h1;
  localparam logic [3:0] KEY_DOWN  = 4'h2;
  localparam logic [3:0] KEY_RIGHT = 4'h3;
  localparam logic [3:0] KEY_UP    = 4'h6;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StPress = 2'd1,
    StGap   = 2'd2
  } emu_state_e;

endpackage

// File: rtl/keypad_matrix_emu_if.sv
// Command and matrix-line bundle between a move source / scanner pair and the keypad emulator.
interface keypad_matrix_emu_if;

  logic       cmd_valid;
  logic [3:0] cmd_code;
  logic       cmd_ready;
  logic [3:0] col;
  logic [3:0] row;
  logic       busy;
  logic       done;

  modport master (
    output cmd_valid, cmd_code, col,
    input  cmd_ready, row, busy, done
  );

  modport slave (
    input  cmd_valid, cmd_code, col,
    output cmd_ready, row, busy, done
  );

endinterface

// File: rtl/keypad_emu_timer.sv
// Loadable down-counter that saturates at zero; shared by the hold and gap phases.
module keypad_emu_timer #(
  parameter int unsigned CNT_W = 22
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  output logic             zero_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/keypad_matrix_emu.sv
// Emulates a 4x4 membrane keypad holding one commanded key: rows echo the matching column strobe.
module keypad_matrix_emu
  import keypad_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES = 2_000_000,
  parameter int unsigned GAP_CYCLES  = 2_000_000,
  parameter int unsigned CNT_W       = 22
) (
  input  logic                 clk,
  input  logic                 rst,
  keypad_matrix_emu_if.slave   bus
);

  localparam logic [CNT_W-1:0] HoldLoad = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GapLoad  = CNT_W'(GAP_CYCLES - 1);

  emu_state_e       state_q, state_d;
  logic [3:0]       key_q, key_d;
  logic [3:0]       row_q, row_d;
  logic             tmr_load;
  logic [CNT_W-1:0] tmr_load_val;
  logic             tmr_zero;
  logic             accept;

  keypad_emu_timer #(
    .CNT_W (CNT_W)
  ) u_timer (
    .clk        (clk),
    .rst        (rst),
    .load_i     (tmr_load),
    .load_val_i (tmr_load_val),
    .zero_o     (tmr_zero)
  );

  assign accept = bus.cmd_valid && (state_q == StIdle);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      key_q   <= 4'h0;
      row_q   <= 4'hF;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      row_q   <= row_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    key_d        = key_q;
    tmr_load     = 1'b0;
    tmr_load_val = HoldLoad;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          key_d    = bus.cmd_code;
          tmr_load = 1'b1;
          state_d  = StPress;
        end
      end
      StPress: begin
        if (tmr_zero) begin
          tmr_load     = 1'b1;
          tmr_load_val = GapLoad;
          state_d      = StGap;
        end
      end
      StGap: begin
        if (tmr_zero) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // A closed switch shorts row r to column c, so row r sees exactly what column c is driven to.
  always_comb begin
    row_d = 4'hF;
    if (state_q == StPress) begin
      row_d[key_q[3:2]] = bus.col[key_q[1:0]];
    end
  end

  always_comb begin
    bus.cmd_ready = (state_q == StIdle);
    bus.busy      = (state_q == StPress) || (state_q == StGap);
    bus.done      = (state_q == StGap) && tmr_zero;
    bus.row       = row_q;
  end

endmodule
